// File: rtl/period_accum_if.sv
// Handshake/data bundle between the constant stage, period_accum and its configuration source.
// The accumulator sits on the slave side; the driving environment takes the master side.
`ifndef DATA_W
`define DATA_W 32
`endif

interface period_accum_if #(
  parameter int DATA_W = `DATA_W,
  parameter int CNT_W  = 10
);
  logic              run;
  logic              running;
  logic              done;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] out0;
  logic              out0_valid;
  logic [CNT_W-1:0]  delay;
  logic [CNT_W-1:0]  period;
  logic [CNT_W-1:0]  iterations;

  modport master (
    output run, in0, delay, period, iterations,
    input  running, done, out0, out0_valid
  );

  modport slave (
    input  run, in0, delay, period, iterations,
    output running, done, out0, out0_valid
  );
endinterface

// File: rtl/period_accum.sv
// Windowed accumulator: after run and a start delay, sums in0 over period cycles and
// publishes each window sum on out0, repeated for iterations windows.
//
// state   | meaning
// S_IDLE  | no job; done=1, waits for run to capture the configuration
// S_DELAY | start delay, down-counts captured delay, in0 ignored
// S_ACCUM | summing in0; window sum published on the last sample of each window
`ifndef DATA_W
`define DATA_W 32
`endif

module period_accum #(
  parameter int DATA_W = `DATA_W,
  parameter int CNT_W  = 10
) (
  input  logic clk,
  input  logic rst,
  period_accum_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_ACCUM = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_dly_cnt;
  logic [CNT_W-1:0]  r_per_last;
  logic [CNT_W-1:0]  r_per_cnt;
  logic [CNT_W-1:0]  r_iter_last;
  logic [CNT_W-1:0]  r_iter_cnt;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_out0;
  logic              r_out_vld;
  logic              r_running;
  logic              r_done;

  state_t            w_state;
  logic [CNT_W-1:0]  w_dly_cnt;
  logic [CNT_W-1:0]  w_per_last;
  logic [CNT_W-1:0]  w_per_cnt;
  logic [CNT_W-1:0]  w_iter_last;
  logic [CNT_W-1:0]  w_iter_cnt;
  logic [DATA_W-1:0] w_acc;
  logic [DATA_W-1:0] w_out0;
  logic              w_out_vld;
  logic              w_running;
  logic              w_done;
  logic [DATA_W-1:0] w_sum;

  assign w_sum = r_acc + bus.in0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dly_cnt   <= '0;
      r_per_last  <= '0;
      r_per_cnt   <= '0;
      r_iter_last <= '0;
      r_iter_cnt  <= '0;
      r_acc       <= '0;
      r_out0      <= '0;
      r_out_vld   <= 1'b0;
      r_running   <= 1'b0;
      r_done      <= 1'b1;
    end else begin
      r_state     <= w_state;
      r_dly_cnt   <= w_dly_cnt;
      r_per_last  <= w_per_last;
      r_per_cnt   <= w_per_cnt;
      r_iter_last <= w_iter_last;
      r_iter_cnt  <= w_iter_cnt;
      r_acc       <= w_acc;
      r_out0      <= w_out0;
      r_out_vld   <= w_out_vld;
      r_running   <= w_running;
      r_done      <= w_done;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_dly_cnt   = r_dly_cnt;
    w_per_last  = r_per_last;
    w_per_cnt   = r_per_cnt;
    w_iter_last = r_iter_last;
    w_iter_cnt  = r_iter_cnt;
    w_acc       = r_acc;
    w_out0      = r_out0;
    w_out_vld   = 1'b0;
    w_running   = r_running;
    w_done      = r_done;

    case (r_state)
      S_IDLE: begin
        w_running = 1'b0;
        w_done    = 1'b1;
        // r_running still high here means a zero-iteration job is finishing; run is ignored
        if (bus.run && !r_running) begin
          w_dly_cnt   = bus.delay;
          w_per_last  = (bus.period == '0) ? '0 : bus.period - CNT_W'(1);
          w_iter_last = bus.iterations - CNT_W'(1);
          w_per_cnt   = '0;
          w_iter_cnt  = '0;
          w_acc       = '0;
          w_running   = 1'b1;
          w_done      = 1'b0;
          if (bus.iterations == '0)
            w_state = S_IDLE;
          else if (bus.delay != '0)
            w_state = S_DELAY;
          else
            w_state = S_ACCUM;
        end
      end

      S_DELAY: begin
        w_dly_cnt = r_dly_cnt - CNT_W'(1);
        if (r_dly_cnt == CNT_W'(1))
          w_state = S_ACCUM;
      end

      S_ACCUM: begin
        if (r_per_cnt == r_per_last) begin
          w_out0     = w_sum;
          w_out_vld  = 1'b1;
          w_acc      = '0;
          w_per_cnt  = '0;
          w_iter_cnt = r_iter_cnt + CNT_W'(1);
          if (r_iter_cnt == r_iter_last) begin
            w_state   = S_IDLE;
            w_running = 1'b0;
            w_done    = 1'b1;
          end
        end else begin
          w_acc     = w_sum;
          w_per_cnt = r_per_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state   = S_IDLE;
        w_running = 1'b0;
        w_done    = 1'b1;
      end
    endcase
  end

  assign bus.out0       = r_out0;
  assign bus.out0_valid = r_out_vld;
  assign bus.running    = r_running;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_period_accum.sv
// Scoreboard bench for period_accum: stimulus pushes expected (sum, edge) pairs,
// a negedge monitor pops one per out0_valid pulse and checks value and timing.
module tb_period_accum;
  localparam int DW = 32;
  localparam int CW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  period_accum_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  period_accum #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] val;
    int            edge_n;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(logic [DW-1:0] v, int e);
    exp_t x;
    x.val    = v;
    x.edge_n = e;
    sbq.push_back(x);
  endtask

  always @(negedge clk) begin
    if (bus.out0_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got out0=%0h at edge %0d want no pulse", bus.out0, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out0_value", 64'(bus.out0), 64'(e.val));
        chk("out0_edge", 64'(cyc), 64'(e.edge_n));
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(int d, int p, int it, output int t);
    bus.delay      = CW'(d);
    bus.period     = CW'(p);
    bus.iterations = CW'(it);
    bus.run        = 1'b1;
    step(1);
    t       = cyc;
    bus.run = 1'b0;
  endtask

  initial begin
    int t;
    bus.run        = 1'b0;
    bus.in0        = '0;
    bus.delay      = '0;
    bus.period     = '0;
    bus.iterations = '0;

    // reset values
    rst = 1'b1;
    step(3);
    chk("rst_out0", 64'(bus.out0), 64'd0);
    chk("rst_valid", 64'(bus.out0_valid), 64'd0);
    chk("rst_running", 64'(bus.running), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd1);
    rst = 1'b0;
    step(1);

    // constant 5, delay 2, period 4, three windows; config changes and run mid-job ignored
    bus.in0 = 32'd5;
    start(2, 4, 3, t);
    push(32'd20, t + 6);
    push(32'd20, t + 10);
    push(32'd20, t + 14);
    chk("s2_running", 64'(bus.running), 64'd1);
    chk("s2_done", 64'(bus.done), 64'd0);
    step(1);
    bus.delay = '0; bus.period = CW'(1); bus.iterations = CW'(7); bus.run = 1'b1;
    step(1);
    bus.run = 1'b0;
    step(11);
    chk("s2_done_early", 64'(bus.done), 64'd0);
    step(1);
    chk("s2_done_end", 64'(bus.done), 64'd1);
    chk("s2_running_end", 64'(bus.running), 64'd0);
    chk("s2_out0_end", 64'(bus.out0), 64'd20);
    step(3);
    chk("s2_out0_hold", 64'(bus.out0), 64'd20);

    // wrap-around: two samples of all-ones
    bus.in0 = 32'hFFFF_FFFF;
    start(0, 2, 1, t);
    push(32'hFFFF_FFFE, t + 2);
    step(2);
    chk("s3_done", 64'(bus.done), 64'd1);
    step(1);

    // zero iterations: one-cycle running, no pulse, out0 untouched
    start(0, 4, 0, t);
    chk("s4_running", 64'(bus.running), 64'd1);
    chk("s4_done", 64'(bus.done), 64'd0);
    step(1);
    chk("s4_running_off", 64'(bus.running), 64'd0);
    chk("s4_done_back", 64'(bus.done), 64'd1);
    chk("s4_out0_kept", 64'(bus.out0), 64'hFFFF_FFFE);
    step(2);

    // period 0 acts as 1: out0 follows the ramp one cycle later
    bus.in0 = 32'd1;
    start(0, 0, 3, t);
    push(32'd1, t + 1);
    push(32'd2, t + 2);
    push(32'd3, t + 3);
    step(1);
    bus.in0 = 32'd2;
    step(1);
    bus.in0 = 32'd3;
    step(1);
    chk("s5_done", 64'(bus.done), 64'd1);
    step(2);

    // mid-job reset after an ignored run pulse, then a clean job
    bus.in0 = 32'd5;
    start(2, 4, 3, t);
    step(1);
    bus.iterations = CW'(1); bus.delay = '0; bus.run = 1'b1;
    step(1);
    bus.run = 1'b0;
    step(2);
    rst = 1'b1;
    step(2);
    chk("s6_rst_out0", 64'(bus.out0), 64'd0);
    chk("s6_rst_valid", 64'(bus.out0_valid), 64'd0);
    chk("s6_rst_running", 64'(bus.running), 64'd0);
    chk("s6_rst_done", 64'(bus.done), 64'd1);
    rst = 1'b0;
    step(1);
    start(2, 4, 3, t);
    push(32'd20, t + 6);
    push(32'd20, t + 10);
    push(32'd20, t + 14);
    step(14);
    chk("s6_done_end", 64'(bus.done), 64'd1);
    chk("s6_out0_end", 64'(bus.out0), 64'd20);
    step(3);

    chk("sb_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
